// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator arbiter: opcodes, FSM state
// encodings and the round-robin pick helper.
package accum_pkg;

    // Operation codes carried on op0/op1
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_ACK  = 2'b10;

    // Picks the requester to serve; only meaningful when req is non-zero.
    // A lone requester wins; on contention the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic rr_last);
        if (req == 2'b11) begin
            return ~rr_last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational arithmetic unit for the shared accumulator.
// Build option ACCUM_SAT_EN: ADD saturates at all-ones and SUB clamps at
// zero, raising ovf_set on a clamp. Without it, arithmetic wraps and
// ovf_set reports the carry-out or borrow.
module accum_alu
    import accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opnd,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             ovf_set
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit holds the carry-out for ADD and the borrow for SUB
    assign sum  = {1'b0, acc} + {1'b0, opnd};
    assign diff = {1'b0, acc} - {1'b0, opnd};

    // Select the result and whether this operation overflowed
    always_comb begin
        result  = acc;
        ovf_set = 1'b0;
        case (op)
            OP_ADD: begin
`ifdef ACCUM_SAT_EN
                result  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                result  = sum[WIDTH-1:0];
`endif
                ovf_set = sum[WIDTH];
            end
            OP_SUB: begin
`ifdef ACCUM_SAT_EN
                result  = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                result  = diff[WIDTH-1:0];
`endif
                ovf_set = diff[WIDTH];
            end
            OP_LOAD: begin
                result  = opnd;
            end
            default: begin
                result  = {WIDTH{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/accum_arbiter.sv
// Two requesters share one accumulator over a 4-phase req/ack handshake.
// Grants alternate round-robin on contention and one operation runs at a
// time (IDLE -> EXEC -> ACK -> IDLE). The operand of a requester whose
// INV_MASK bit is set is inverted at grant (active-low switch bank).
// Build option ACCUM_SAT_EN selects saturating arithmetic in accum_alu.
module accum_arbiter
    import accum_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter logic [1:0] INV_MASK = 2'b00
) (
    input  logic             slowclk,
    input  logic             resetn,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] opnd0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] opnd1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] acc_out,
    output logic             ovf
);

    logic [1:0]       state_q,   state_d;
    logic             grant_q,   grant_d;
    logic             rr_last_q, rr_last_d;
    logic [1:0]       op_q,      op_d;
    logic [WIDTH-1:0] opnd_q,    opnd_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic             ovf_q,     ovf_d;
    logic [1:0]       ack_q,     ack_d;

    logic             pick;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf_set;

    accum_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .acc    (acc_q),
        .opnd   (opnd_q),
        .op     (op_q),
        .result (alu_result),
        .ovf_set(alu_ovf_set)
    );

    assign pick    = rr_pick(req, rr_last_q);
    assign ack     = ack_q;
    assign busy    = (state_q != ST_IDLE);
    assign acc_out = acc_q;
    assign ovf     = ovf_q;

    // Handshake controller: grant and latch in IDLE, compute in EXEC, hold ack until req drops
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        ack_d     = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    grant_d = pick;
                    if (pick) begin
                        op_d   = op1;
                        opnd_d = INV_MASK[1] ? ~opnd1 : opnd1;
                    end else begin
                        op_d   = op0;
                        opnd_d = INV_MASK[0] ? ~opnd0 : opnd0;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = alu_result;
                ovf_d   = (op_q == OP_CLEAR) ? 1'b0 : (ovf_q | alu_ovf_set);
                ack_d   = grant_q ? 2'b10 : 2'b01;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!req[grant_q]) begin
                    ack_d     = 2'b00;
                    rr_last_d = grant_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and favours requester 0 next
    always_ff @(posedge slowclk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            op_q      <= OP_ADD;
            opnd_q    <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            ovf_q     <= 1'b0;
            ack_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_d;
        end
    end

endmodule

// File: tb/tb_accum_arbiter.sv
// Self-checking bench for accum_arbiter. A transaction-level model tracks
// the accumulator, the sticky overflow flag and who was served last.
// Honours ACCUM_SAT_EN for the expected arithmetic.
module tb_accum_arbiter;

    localparam logic [1:0] TB_INV = 2'b01;

    logic       slowclk;
    logic       resetn;
    logic [1:0] req;
    logic [1:0] op0;
    logic [7:0] opnd0;
    logic [1:0] op1;
    logic [7:0] opnd1;
    logic [1:0] ack;
    logic       busy;
    logic [7:0] acc_out;
    logic       ovf;

    int checks = 0;
    int passes = 0;

    // Reference state: accumulator value, overflow flag, requester served last
    int m_acc = 0;
    bit m_ovf = 1'b0;
    int m_rr  = 1;

    accum_arbiter #(
        .WIDTH   (8),
        .INV_MASK(TB_INV)
    ) dut (
        .slowclk(slowclk),
        .resetn (resetn),
        .req    (req),
        .op0    (op0),
        .opnd0  (opnd0),
        .op1    (op1),
        .opnd1  (opnd1),
        .ack    (ack),
        .busy   (busy),
        .acc_out(acc_out),
        .ovf    (ovf)
    );

    // Free-running clock
    initial slowclk = 1'b0;
    always #5 slowclk = ~slowclk;

    // Hard stop in case the run ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge slowclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applies one operation to the reference model using plain integer arithmetic
    function automatic void modelOp(input int r, input logic [1:0] op, input logic [7:0] raw);
        logic [1:0] inv;
        logic [7:0] vv;
        int v;
        inv = TB_INV;
        vv  = inv[r] ? ~raw : raw;
        v   = int'(vv);
        case (op)
            2'b00: begin
                v = m_acc + v;
                if (v > 255) begin
                    m_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
                    v = 255;
`else
                    v = v - 256;
`endif
                end
                m_acc = v;
            end
            2'b01: begin
                v = m_acc - v;
                if (v < 0) begin
                    m_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
                    v = 0;
`else
                    v = v + 256;
`endif
                end
                m_acc = v;
            end
            2'b10: m_acc = v;
            default: begin
                m_acc = 0;
                m_ovf = 1'b0;
            end
        endcase
    endfunction

    // Holds reset with both requests high and checks outputs stay cleared
    task automatic doReset();
        resetn = 1'b0;
        req    = 2'b11;
        op0    = 2'($urandom_range(0, 3));
        op1    = 2'($urandom_range(0, 3));
        opnd0  = 8'($urandom_range(0, 255));
        opnd1  = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("reset_acc", 32'(acc_out), 0);
            checkOutput("reset_ack", 32'(ack), 0);
            checkOutput("reset_busy", 32'(busy), 0);
            checkOutput("reset_ovf", 32'(ovf), 0);
        end
        resetn = 1'b1;
        req    = 2'b00;
        m_acc  = 0;
        m_ovf  = 1'b0;
        m_rr   = 1;
    endtask

    // Runs one full handshake and checks grant, latency, result and release
    task automatic applyStimulus(input logic [1:0] req_v,
                                 input logic [1:0] o0, input logic [7:0] d0,
                                 input logic [1:0] o1, input logic [7:0] d1,
                                 input int hold);
        int g;
        logic [1:0] gmask;
        logic [1:0] gop;
        logic [7:0] gd;
        g     = (req_v == 2'b11) ? (1 - m_rr) : (req_v[1] ? 1 : 0);
        gmask = (g == 1) ? 2'b10 : 2'b01;
        gop   = (g == 1) ? o1 : o0;
        gd    = (g == 1) ? d1 : d0;
        op0   = o0;
        opnd0 = d0;
        op1   = o1;
        opnd1 = d1;
        req   = req_v;
        tick();
        checkOutput("busy_after_grant", 32'(busy), 1);
        checkOutput("ack_during_exec", 32'(ack), 0);
        op0   = 2'($urandom_range(0, 3));
        op1   = 2'($urandom_range(0, 3));
        opnd0 = 8'($urandom_range(0, 255));
        opnd1 = 8'($urandom_range(0, 255));
        req   = gmask | (($urandom_range(0, 1) == 1) ? ~gmask : 2'b00);
        tick();
        modelOp(g, gop, gd);
        checkOutput("ack_grant", 32'(ack), 32'(gmask));
        checkOutput("acc_result", 32'(acc_out), m_acc);
        checkOutput("ovf_result", 32'(ovf), 32'(m_ovf));
        for (int i = 0; i < hold; i++) begin
            req = gmask | (($urandom_range(0, 1) == 1) ? ~gmask : 2'b00);
            tick();
            checkOutput("ack_hold", 32'(ack), 32'(gmask));
        end
        req = ($urandom_range(0, 1) == 1) ? ~gmask : 2'b00;
        tick();
        checkOutput("ack_release", 32'(ack), 0);
        checkOutput("busy_release", 32'(busy), 0);
        checkOutput("acc_stable", 32'(acc_out), m_acc);
        m_rr = g;
        req  = 2'b00;
    endtask

    initial begin
        logic [7:0] raw [2];
        logic [1:0] exp_mask;
        int n;

        $display("[TB] start");
        resetn = 1'b1;
        req    = 2'b00;
        op0    = 2'b00;
        op1    = 2'b00;
        opnd0  = 8'h00;
        opnd1  = 8'h00;
        #2;
        doReset();

        // Basic ADD from requester 0 (inverted bank: FA becomes 05)
        applyStimulus(2'b01, 2'b00, 8'hFA, 2'b00, 8'h00, 1);
        checkOutput("basic_acc", 32'(acc_out), 32'h05);

        // Clear, then inverted operand FE becomes 01
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b11, 8'h00, 0);
        applyStimulus(2'b01, 2'b00, 8'hFE, 2'b00, 8'h00, 0);
        checkOutput("invert_acc", 32'(acc_out), 32'h01);

        // Overflow on ADD, then CLEAR, then borrow on SUB
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b10, 8'hFF, 0);
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b00, 8'h02, 0);
`ifdef ACCUM_SAT_EN
        checkOutput("ovf_add_acc", 32'(acc_out), 32'hFF);
`else
        checkOutput("ovf_add_acc", 32'(acc_out), 32'h01);
`endif
        checkOutput("ovf_add_flag", 32'(ovf), 1);
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b10, 8'h07, 0);
        checkOutput("ovf_sticky_load", 32'(ovf), 1);
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b11, 8'h55, 0);
        checkOutput("clear_acc", 32'(acc_out), 0);
        checkOutput("clear_ovf", 32'(ovf), 0);
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b01, 8'h01, 0);
`ifdef ACCUM_SAT_EN
        checkOutput("sub_borrow_acc", 32'(acc_out), 32'h00);
`else
        checkOutput("sub_borrow_acc", 32'(acc_out), 32'hFF);
`endif
        checkOutput("sub_borrow_ovf", 32'(ovf), 1);

        // Contention: both held, each drops on its ack and re-raises
        doReset();
        raw[0] = 8'($urandom_range(0, 255));
        raw[1] = 8'($urandom_range(0, 255));
        op0    = 2'b00;
        opnd0  = raw[0];
        op1    = 2'b00;
        opnd1  = raw[1];
        req    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_mask = ((k % 2) == 1) ? 2'b10 : 2'b01;
            n = 0;
            while (ack == 2'b00 && n < 6) begin
                tick();
                n++;
            end
            checkOutput("contention_grant", 32'(ack), 32'(exp_mask));
            modelOp(k % 2, 2'b00, raw[k % 2]);
            checkOutput("contention_acc", 32'(acc_out), m_acc);
            req = req & ~exp_mask;
            tick();
            checkOutput("contention_release", 32'(ack), 0);
            m_rr = k % 2;
            req  = 2'b11;
        end
        req = 2'b00;
        tick();

        // Abort: reset while an ADD is in EXEC
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b10, 8'h20, 0);
        op1   = 2'b00;
        opnd1 = 8'h10;
        req   = 2'b10;
        tick();
        checkOutput("abort_busy_exec", 32'(busy), 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("abort_acc", 32'(acc_out), 0);
        checkOutput("abort_ack", 32'(ack), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        tick();
        tick();
        checkOutput("abort_ack_held", 32'(ack), 0);
        checkOutput("abort_acc_held", 32'(acc_out), 0);
        resetn = 1'b1;
        req    = 2'b00;
        m_acc  = 0;
        m_ovf  = 1'b0;
        m_rr   = 1;
        applyStimulus(2'b10, 2'b00, 8'h00, 2'b00, 8'h33, 0);
        checkOutput("abort_recover_acc", 32'(acc_out), 32'h33);

        // Randomised traffic against the model
        for (int t = 0; t < 40; t++) begin
            applyStimulus(2'($urandom_range(1, 3)),
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                          int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
